// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl -- controller for a set-associative, write-back data cache with
// a 32-byte (8-word) line and 16 sets. The SRAM array and its way selection
// and LRU sit outside this block. The SRAM reports a combinational hit and
// presents either the hit way or the LRU victim way.
//
// Optional feature (build macro DCACHE_STATS_EN): adds hit/miss statistics
// counters hit_cnt_o / miss_cnt_o of width STAT_W. Both counters saturate.
//
// Ports
//   clk_i, rst_i      clock; asynchronous active-low reset
//   cpu_addr_i        byte address: tag [31:9], index [8:5], word [4:2]
//   cpu_data_i        CPU write data
//   cpu_MemRead_i     read request (held while cpu_stall_o=1)
//   cpu_MemWrite_i    write request (wins over read when both are set)
//   cpu_data_o        read data on a read hit, otherwise 0
//   cpu_stall_o       CPU must hold its request
//   mem_data_i        fill line, valid with mem_ack_i
//   mem_ack_i         one-cycle completion pulse from memory
//   mem_enable_o      one-cycle memory request pulse
//   mem_write_o       1 = writeback, 0 = fill
//   mem_addr_o        line address (bits [4:0] = 0)
//   mem_data_o        writeback line
//   sram_addr_o       set index
//   sram_tag_o        {valid, dirty, tag[22:0]} to write
//   sram_data_o       line to write
//   sram_enable_o     SRAM access enable
//   sram_write_o      SRAM write strobe
//   sram_tag_i        tag of the hit way (hit) or victim way (miss)
//   sram_data_i       line of the same way as sram_tag_i
//   sram_hit_i        combinational hit indication
//   hit_cnt_o         (DCACHE_STATS_EN) hits, excluding the post-fill replay
//   miss_cnt_o        (DCACHE_STATS_EN) IDLE->MISS transitions
//   fsm_state         current FSM state (IDLE=0 MISS=1 WRITEBACK=2
//                     READMISS=3 READMISSOK=4), for observation only
//
// Handshake: the CPU request is level-held. A request counts as accepted in
// the cycle where req=1 and cpu_stall_o=0. The memory side is request-pulse
// and ack-pulse: mem_enable_o is high for exactly one cycle per transaction,
// and mem_ack_i is a one-cycle pulse that is honoured only in WRITEBACK and
// READMISS.
// ---------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int STAT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    input  logic [255:0]      mem_data_i,
    input  logic              mem_ack_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [255:0]      mem_data_o,
    output logic [3:0]        sram_addr_o,
    output logic [24:0]       sram_tag_o,
    output logic [255:0]      sram_data_o,
    output logic              sram_enable_o,
    output logic              sram_write_o,
    input  logic [24:0]       sram_tag_i,
    input  logic [255:0]      sram_data_i,
    input  logic              sram_hit_i,
`ifdef DCACHE_STATS_EN
    output logic [STAT_W-1:0] hit_cnt_o,
    output logic [STAT_W-1:0] miss_cnt_o,
`endif
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        WRITEBACK  = 3'd2,
        READMISS   = 3'd3,
        READMISSOK = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic         req;
    logic [3:0]   index;
    logic [22:0]  cpu_tag;
    logic [2:0]   word;
    logic [7:0]   word_lsb;
    logic         victim_dirty;
    logic [31:0]  fill_addr;
    logic [31:0]  hit_word;
    logic [255:0] merged_line;

    assign req          = cpu_MemRead_i | cpu_MemWrite_i;
    assign index        = cpu_addr_i[8:5];
    assign cpu_tag      = cpu_addr_i[31:9];
    assign word         = cpu_addr_i[4:2];
    assign word_lsb     = {word, 5'b0};
    assign victim_dirty = sram_tag_i[24] & sram_tag_i[23];
    assign fill_addr    = {cpu_tag, index, 5'b0};
    assign hit_word     = sram_data_i[word_lsb +: 32];
    assign fsm_state    = state;

    // Hit line with the addressed word replaced by the CPU write data.
    always_comb begin
        merged_line = sram_data_i;
        merged_line[word_lsb +: 32] = cpu_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        sram_addr_o   = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        // While reset is asserted every output is held at 0, even though
        // several outputs are otherwise combinational from the CPU inputs.
        if (rst_i) begin
            sram_addr_o = index;
            cpu_stall_o = req & ~((state == IDLE) & sram_hit_i);
            case (state)
                IDLE: begin
                    sram_enable_o = req;
                    if (req) begin
                        if (sram_hit_i) begin
                            if (cpu_MemWrite_i) begin
                                sram_write_o = 1'b1;
                                sram_data_o  = merged_line;
                                sram_tag_o   = {2'b11, cpu_tag};
                            end else begin
                                cpu_data_o = hit_word;
                            end
                        end else begin
                            next_state = MISS;
                        end
                    end
                end
                MISS: begin
                    // The SRAM presents the LRU victim here. Write it back
                    // only if it holds modified data.
                    mem_enable_o = 1'b1;
                    if (victim_dirty) begin
                        mem_write_o = 1'b1;
                        mem_addr_o  = {sram_tag_i[22:0], index, 5'b0};
                        mem_data_o  = sram_data_i;
                        next_state  = WRITEBACK;
                    end else begin
                        mem_addr_o  = fill_addr;
                        next_state  = READMISS;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_enable_o = 1'b1;
                        mem_addr_o   = fill_addr;
                        next_state   = READMISS;
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        sram_enable_o = 1'b1;
                        sram_write_o  = 1'b1;
                        sram_tag_o    = {2'b10, cpu_tag};
                        sram_data_o   = mem_data_i;
                        next_state    = READMISSOK;
                    end
                end
                READMISSOK: begin
                    // One cycle lets the SRAM settle. The held request then
                    // replays in IDLE as an ordinary hit.
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    // High in the IDLE cycle right after a fill. That cycle is the replay of
    // the missed request, so it does not count as a hit.
    logic replay_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            replay_q   <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            replay_q <= (state == READMISSOK);
            if (state == IDLE && req) begin
                if (sram_hit_i) begin
                    if (!replay_q && hit_cnt_o != '1) begin
                        hit_cnt_o <= hit_cnt_o + STAT_ONE;
                    end
                end else if (miss_cnt_o != '1) begin
                    miss_cnt_o <= miss_cnt_o + STAT_ONE;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl -- bench for dcache_ctrl. A one-way SRAM model answers the
// controller. The stimulus pushes the expected memory pulses, SRAM writes
// and read data into queues. A monitor on the falling edge pops the queues
// and compares them against the events the DUT presents.
// ---------------------------------------------------------------------------
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic         cpu_MemRead_i = 1'b0;
    logic         cpu_MemWrite_i = 1'b0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    logic [2:0]   fsm_state;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    dcache_ctrl #(.STAT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
        .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o),
        .sram_write_o(sram_write_o), .sram_tag_i(sram_tag_i),
        .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
`ifdef DCACHE_STATS_EN
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt),
`endif
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- one-way SRAM model ----------------
    logic [24:0]  tag_mem [16];
    logic [255:0] data_mem[16];
    logic         pre_en = 1'b0;
    logic [3:0]   pre_idx = '0;
    logic [24:0]  pre_tag = '0;
    logic [255:0] pre_data = '0;

    assign sram_tag_i  = tag_mem[sram_addr_o];
    assign sram_data_i = data_mem[sram_addr_o];
    assign sram_hit_i  = tag_mem[sram_addr_o][24] &&
                         (tag_mem[sram_addr_o][22:0] == cpu_addr_i[31:9]);

    always @(posedge clk_i) begin
        if (pre_en) begin
            tag_mem[pre_idx]  <= pre_tag;
            data_mem[pre_idx] <= pre_data;
        end else if (sram_enable_o && sram_write_o) begin
            tag_mem[sram_addr_o]  <= sram_tag_o;
            data_mem[sram_addr_o] <= sram_data_o;
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    logic prev_en = 1'b0;
    logic [288:0] mem_q[$];   // {write, addr[31:0], data[255:0]}
    logic [280:0] sram_q[$];  // {tag[24:0], data[255:0]}
    logic [31:0]  cpu_q[$];   // read data

    task automatic check(input string name, input logic [288:0] act, input logic [288:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event required none", name);
    endtask

    function automatic logic [255:0] line_pat(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
        return l;
    endfunction

    always @(negedge clk_i) begin
        logic [288:0] me;
        logic [280:0] se;
        if (rst_i) begin
            if (mem_enable_o) begin
                pulses++;
                check("mem_pulse_single", prev_en, 1'b0);
                if (mem_q.size() == 0) unexpected("mem_pulse");
                else begin
                    me = mem_q.pop_front();
                    check("mem_write", mem_write_o, me[288]);
                    check("mem_addr", mem_addr_o, me[287:256]);
                    if (me[288]) check("mem_wb_data", mem_data_o, me[255:0]);
                end
            end
            if (sram_enable_o && sram_write_o) begin
                if (sram_q.size() == 0) unexpected("sram_write");
                else begin
                    se = sram_q.pop_front();
                    check("sram_tag", sram_tag_o, se[280:256]);
                    check("sram_data", sram_data_o, se[255:0]);
                end
            end
            if (cpu_MemRead_i && !cpu_MemWrite_i && !cpu_stall_o) begin
                if (cpu_q.size() == 0) unexpected("cpu_read");
                else check("cpu_data", cpu_data_o, cpu_q.pop_front());
            end
        end
        prev_en = mem_enable_o;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        cpu_addr_i     = a;
        cpu_data_i     = d;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [24:0] t, input logic [255:0] d);
        @(posedge clk_i); #1;
        pre_en = 1'b1; pre_idx = idx; pre_tag = t; pre_data = d;
        @(posedge clk_i); #1;
        pre_en = 1'b0;
    endtask

    task automatic wait_pulse(input string name);
        logic seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk_i);
            if (mem_enable_o) seen = 1'b1;
        end
        check(name, seen, 1'b1);
    endtask

    task automatic ack_after(input int n, input logic [255:0] line);
        repeat (n) @(posedge clk_i);
        #1 mem_ack_i = 1'b1; mem_data_i = line;
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0; mem_data_i = '0;
    endtask

    task automatic hit_read(input logic [31:0] a, input logic [31:0] exp);
        @(posedge clk_i); #1;
        drive(1'b1, 1'b0, a, 32'h0);
        cpu_q.push_back(exp);
        @(negedge clk_i);
        check("hit_read_stall", cpu_stall_o, 1'b0);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, a, 32'h0);
    endtask

    // Clean read miss: one fill pulse, ack after 10 cycles, stall released
    // on the second cycle after the ack cycle.
    task automatic clean_miss(input logic [31:0] a, input logic [22:0] t,
                              input logic [255:0] line, input logic [31:0] exp);
        int p0;
        p0 = pulses;
        mem_q.push_back({1'b0, {a[31:5], 5'b0}, 256'h0});
        sram_q.push_back({2'b10, t, line});
        cpu_q.push_back(exp);
        @(posedge clk_i); #1;
        drive(1'b1, 1'b0, a, 32'h0);
        @(negedge clk_i);
        check("miss_stall", cpu_stall_o, 1'b1);
        wait_pulse("fill_pulse_seen");
        ack_after(10, line);
        @(negedge clk_i);
        check("stall_1_after_ack", cpu_stall_o, 1'b1);
        @(negedge clk_i);
        check("stall_2_after_ack", cpu_stall_o, 1'b0);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, a, 32'h0);
        check("clean_miss_pulses", pulses - p0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] l1;
        logic [255:0] l4;
        int p0;
        // Reset with a request already asserted: the outputs must stay at 0.
        drive(1'b1, 1'b0, 32'h0000_0124, 32'h0);
        for (int i = 0; i < 16; i++) preload(4'(i), 25'h0, 256'h0);
        preload(4'd9, 25'h1000000, line_pat(32'h1000_0000));
        preload(4'd3, {2'b11, 23'h5}, line_pat(32'h3000_0000));
        @(negedge clk_i);
        check("rst_state", fsm_state, 3'd0);
        check("rst_stall", cpu_stall_o, 1'b0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
        check("rst_sram_en", sram_enable_o, 1'b0);
        check("rst_sram_addr", sram_addr_o, 4'h0);
        check("rst_mem_en", mem_enable_o, 1'b0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'h0);
        check("rst_miss_cnt", miss_cnt, 32'h0);
`endif
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1 rst_i = 1'b1;

        // Read hit: address 0x124 -> set 9, word 1.
        hit_read(32'h0000_0124, 32'h1000_0001);

        // Clean read miss: address 0x200 -> set 0, tag 1.
        clean_miss(32'h0000_0200, 23'h1, line_pat(32'h2000_0000), 32'h2000_0000);

        // Dirty write miss at 0xE68 (tag 7, set 3, word 2). The victim has
        // tag 5 and is written back to 0xA60, then the fill of 0xE60 follows.
        p0 = pulses;
        l4 = line_pat(32'h4000_0000);
        mem_q.push_back({1'b1, 32'h0000_0A60, line_pat(32'h3000_0000)});
        mem_q.push_back({1'b0, 32'h0000_0E60, 256'h0});
        sram_q.push_back({2'b10, 23'h7, l4});
        l1 = l4;
        l1[95:64] = 32'hCAFE_F00D;
        sram_q.push_back({2'b11, 23'h7, l1});
        @(posedge clk_i); #1;
        drive(1'b0, 1'b1, 32'h0000_0E68, 32'hCAFE_F00D);
        wait_pulse("wb_pulse_seen");
        ack_after(3, 256'h0);
        @(negedge clk_i);
        check("state_readmiss", fsm_state, 3'd3);
        ack_after(4, l4);
        @(negedge clk_i);
        check("dirty_stall_1", cpu_stall_o, 1'b1);
        @(negedge clk_i);
        check("dirty_stall_2", cpu_stall_o, 1'b0);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("dirty_miss_pulses", pulses - p0, 2);

        // Write hit on word 7 of set 9 (address 0x13C): dirty bit set and
        // only the top word changes.
        l1 = line_pat(32'h1000_0000);
        l1[255:224] = 32'hDEAD_BEEF;
        sram_q.push_back({2'b11, 23'h0, l1});
        @(posedge clk_i); #1;
        drive(1'b0, 1'b1, 32'h0000_013C, 32'hDEAD_BEEF);
        @(negedge clk_i);
        check("write_hit_stall", cpu_stall_o, 1'b0);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during READMISS (miss on 0x4A0 -> set 5), then a late ack.
        mem_q.push_back({1'b0, 32'h0000_04A0, 256'h0});
        @(posedge clk_i); #1;
        drive(1'b1, 1'b0, 32'h0000_04A0, 32'h0);
        wait_pulse("rst_test_pulse_seen");
        @(negedge clk_i);
        check("rst_test_readmiss", fsm_state, 3'd3);
        #1 rst_i = 1'b0;
        #1;
        check("midrst_state", fsm_state, 3'd0);
        check("midrst_stall", cpu_stall_o, 1'b0);
        check("midrst_sram_addr", sram_addr_o, 4'h0);
        check("midrst_sram_en", sram_enable_o, 1'b0);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        rst_i = 1'b1;
        #1 mem_ack_i = 1'b1; mem_data_i = line_pat(32'h5000_0000);
        @(negedge clk_i);
        check("late_ack_no_sram_write", sram_write_o, 1'b0);
        check("late_ack_no_mem_en", mem_enable_o, 1'b0);
        check("late_ack_state", fsm_state, 3'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0; mem_data_i = '0;
        @(negedge clk_i);
        check("after_ack_state", fsm_state, 3'd0);
`ifdef DCACHE_STATS_EN
        check("midrst_hit_cnt", hit_cnt, 32'h0);
        check("midrst_miss_cnt", miss_cnt, 32'h0);
`endif

        // Three hits and one miss. The replay after the fill is not a hit.
        hit_read(32'h0000_0124, 32'h1000_0001);
        hit_read(32'h0000_013C, 32'hDEAD_BEEF);
        clean_miss(32'h0000_0604, 23'h3, line_pat(32'h6000_0000), 32'h6000_0001);
        hit_read(32'h0000_0124, 32'h1000_0001);
        @(negedge clk_i);
`ifdef DCACHE_STATS_EN
        check("hit_cnt", hit_cnt, 32'd3);
        check("miss_cnt", miss_cnt, 32'd1);
`endif

        repeat (2) @(negedge clk_i);
        check("queues_drained", mem_q.size() + sram_q.size() + cpu_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter STAT_W, default 32, width of the statistics counters (used only with DCACHE_STATS_EN).
REQ-002 SHALL have clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have the CPU-side ports:
- cpu_addr_i  in  32  byte address: tag [31:9], index [8:5], word [4:2]
- cpu_data_i  in  32  write data
- cpu_MemRead_i  in  1  read request
- cpu_MemWrite_i  in  1  write request
- cpu_data_o  out  32  read data
- cpu_stall_o  out  1  CPU must hold its request
REQ-005 SHALL have the memory-side ports:
- mem_data_i  in  256  fill line, valid when mem_ack_i=1
- mem_ack_i  in  1  one-cycle completion pulse
- mem_enable_o  out  1  one-cycle request pulse
- mem_write_o  out  1  1 = writeback, 0 = fill
- mem_addr_o  out  32  line address, [4:0]=0
- mem_data_o  out  256  writeback line
REQ-006 SHALL have the SRAM-side ports:
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid[24], dirty[23], tag[22:0]}
- sram_data_o  out  256  line to write
- sram_enable_o  out  1  access enable
- sram_write_o  out  1  write strobe
- sram_tag_i  in  25  hit way on hit, LRU victim way on miss
- sram_data_i  in  256  same way as sram_tag_i
- sram_hit_i  in  1  combinational hit

Function
REQ-007 SHALL use FSM states IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
REQ-008 SHALL treat req = cpu_MemRead_i | cpu_MemWrite_i; MemWrite wins when both are set.
REQ-009 SHALL drive sram_addr_o = cpu_addr_i[8:5] in every state, and sram_enable_o = req in IDLE.
REQ-010 SHALL drive cpu_stall_o = req & ~(state==IDLE & sram_hit_i), combinationally; a hit costs 0 stall cycles.
REQ-011 SHALL set cpu_data_o = sram_data_i word [32*w+31:32*w], with w = cpu_addr_i[4:2], on a read hit; cpu_data_o SHALL be 0 otherwise.
REQ-012 SHALL handle a write hit in the same cycle:
- sram_write_o=1
- sram_data_o = sram_data_i with word w replaced by cpu_data_i
- sram_tag_o = {1,1,cpu_addr_i[31:9]}
REQ-013 SHALL move IDLE -> MISS on req & ~sram_hit_i.
REQ-014 SHALL, in MISS with victim valid & dirty, pulse mem_enable_o with mem_write_o=1, mem_addr_o={victim tag,index,5'b0} and mem_data_o=sram_data_i, then go to WRITEBACK.
REQ-015 SHALL, in MISS otherwise, pulse mem_enable_o with mem_write_o=0 and mem_addr_o={cpu tag,index,5'b0}, then go to READMISS.
REQ-016 SHALL, in WRITEBACK on mem_ack_i, issue the fill request of REQ-015 and go to READMISS.
REQ-017 SHALL, in READMISS on mem_ack_i, assert sram_enable_o=1 and sram_write_o=1 with sram_tag_o={1,0,cpu tag} and sram_data_o=mem_data_i, then go to READMISSOK.
REQ-018 SHALL go READMISSOK -> IDLE unconditionally; the held request then completes as a hit, and a write sets dirty.
REQ-019 SHALL never hold mem_enable_o high for more than one cycle.
REQ-020 SHALL ignore mem_ack_i in IDLE and MISS.
REQ-021 SHALL complete an outstanding fill even if req drops mid-miss.

Reset
REQ-022 SHALL, on rst_i=0 at any time including mid-miss, go to IDLE with all outputs 0 and all counters 0; a late mem_ack_i is then ignored per REQ-020.

Configuration
REQ-023 SHALL use macro DCACHE_STATS_EN; when defined, SHALL add outputs hit_cnt_o and miss_cnt_o (out, STAT_W):
- miss_cnt_o increments on each IDLE->MISS transition
- hit_cnt_o increments on each IDLE hit cycle except the replay cycle right after READMISSOK
- both saturate at all-ones
REQ-024 SHALL omit those ports and counters when DCACHE_STATS_EN is undefined, with identical behaviour otherwise.

Verification
REQ-025 SHALL cover: read hit, sram_hit_i=1, addr 0x0000_0124 -> cpu_stall_o=0 same cycle, cpu_data_o = word 1 of the line.
REQ-026 SHALL cover: clean read miss, addr 0x0000_0200 -> one mem pulse with write=0 and addr 0x200; ack after 10 cycles -> SRAM written with tag {1,0,0x000001}; stall released 2 cycles after ack.
REQ-027 SHALL cover: dirty miss, victim tag 0x000005, index 3 -> writeback to 0x0000_0A60, then fill pulse; exactly two mem_enable_o pulses in total.
REQ-028 SHALL cover: write hit with data 0xDEADBEEF, word 7 -> sram_data_o[255:224]=0xDEADBEEF, other words unchanged, dirty bit 1.
REQ-029 SHALL cover: rst_i=0 during READMISS, then ack -> state IDLE, no SRAM write, all outputs 0.
REQ-030 SHALL cover, with DCACHE_STATS_EN: 3 hits and 1 miss -> hit_cnt_o=3 and miss_cnt_o=1, with the replay hit not counted.
